// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: sequencer states, byte width,
// and a constant-evaluable log2 helper for pointer and counter widths.
package uart_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FETCH     = 3'd1,
      START     = 3'd2,
      WAIT_BUSY = 3'd3,
      WAIT_DONE = 3'd4
   } state_t;

   // Smallest r such that 2**r >= value (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping to index 0. grant is one-hot (or zero when nothing requests).
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic             any
);

   assign any = |req;

   // Two passes: indices >= ptr first, then the wrapped-around low indices.
   always_comb begin
      logic found;
      grant = '0;
      found = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
         if (!found && (j >= int'(ptr)) && req[j]) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int j = 0; j < N_REQ; j++) begin
         if (!found && req[j]) begin
            grant[j] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX core between N_REQ byte-stream
// requesters. The channel is locked to one requester for a whole packet;
// each byte is handed to the core with a start pulse and tracked through the
// core's busy flag. Any wait state lasting TIMEOUT_CYC cycles aborts the
// packet, pulses timeout_err and moves the round-robin pointer on.
//
// Handshake: a requester byte transfers on a rising clk edge where
// req_valid[i] & req_ready[i] are both high. req_ready is only ever raised
// for the granted requester while in FETCH and mirrors its req_valid
// combinationally; req_last is only meaningful on a transfer cycle.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int CLK_FREQ    = 100_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int TIMEOUT_CYC = 12 * CLK_FREQ / BAUD_RATE,
   localparam int PTR_W      = (N_REQ > 1) ? clog2(N_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_last,
   input  logic [BYTE_W*N_REQ-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    tx_start,
   output logic [BYTE_W-1:0]       tx_data,
   input  logic                    tx_busy,
   output logic [N_REQ-1:0]        grant,
   output logic                    active,
   output logic                    timeout_err,
   output state_t                  state_dbg,
   output logic [PTR_W-1:0]        ptr_dbg
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? clog2(TIMEOUT_CYC) : 1;

   state_t              state_q, state_d;
   logic [N_REQ-1:0]    grant_q;
   logic [PTR_W-1:0]    ptr_q, ptr_next, gidx;
   logic [CNT_W-1:0]    cnt_q;
   logic                last_q;
   logic [BYTE_W-1:0]   tx_data_q;
   logic                timeout_q;

   logic [N_REQ-1:0]    arb_grant;
   logic                arb_any;
   logic [BYTE_W-1:0]   sel_data;
   logic                sel_last;
   logic                sel_valid;
   logic                cnt_hit;
   logic                count_en;
   logic                abort;
   logic                pkt_done;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .any   (arb_any)
   );

   // Route the granted requester's byte, last flag and index (grant is one-hot).
   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      gidx     = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (grant_q[j]) begin
            sel_data = req_data[j*BYTE_W +: BYTE_W];
            sel_last = req_last[j];
            gidx     = PTR_W'(j);
         end
      end
   end

   assign sel_valid = |(req_valid & grant_q);
   assign cnt_hit   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
   assign ptr_next  = (gidx == PTR_W'(N_REQ - 1)) ? '0 : gidx + PTR_W'(1);

   // Next-state logic; a normal transition wins over a timeout in the same cycle.
   always_comb begin
      state_d  = state_q;
      count_en = 1'b0;
      abort    = 1'b0;
      pkt_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_any) state_d = FETCH;
         end
         FETCH: begin
            count_en = !last_q;
            if (sel_valid) begin
               state_d = START;
            end else if (cnt_hit && !last_q) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         START: begin
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            count_en = 1'b1;
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (cnt_hit) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         WAIT_DONE: begin
            count_en = 1'b1;
            if (!tx_busy) begin
               pkt_done = last_q;
               state_d  = last_q ? IDLE : FETCH;
            end else if (cnt_hit) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Ready mirrors valid for the grantee only while fetching.
   always_comb begin
      req_ready = '0;
      if (state_q == FETCH) req_ready = req_valid & grant_q;
   end

   // State, grant/pointer bookkeeping, wait counter and captured byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         last_q    <= 1'b0;
         tx_data_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         timeout_q <= abort;
         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (count_en) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if ((state_q == IDLE) && arb_any) begin
            grant_q <= arb_grant;
            last_q  <= 1'b0;
         end else if (pkt_done || abort) begin
            grant_q <= '0;
            ptr_q   <= ptr_next;
         end
         if ((state_q == FETCH) && sel_valid) begin
            tx_data_q <= sel_data;
            last_q    <= sel_last;
         end
      end
   end

   assign tx_start    = (state_q == START);
   assign tx_data     = tx_data_q;
   assign grant       = grant_q;
   assign active      = (state_q != IDLE);
   assign timeout_err = timeout_q;
   assign state_dbg   = state_q;
   assign ptr_dbg     = ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requester sources, a TX core model that
// stays busy for 100 cycles per byte, a packet-level round-robin model that
// fills the expected queue, and a monitor that checks every start pulse.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int N        = 4;
   localparam int W        = 12;   // {grant one-hot, byte}
   localparam int BUSY_CYC = 100;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid, req_last, req_ready, grant;
   logic [8*N-1:0] req_data;
   logic           tx_start, tx_busy, active, timeout_err;
   logic [7:0]     tx_data;
   state_t         state_dbg;
   logic [1:0]     ptr_dbg;

   int n_cmp = 0;
   int n_err = 0;

   uart_tx_arbiter #(
      .N_REQ     (N),
      .CLK_FREQ  (1_152_000),
      .BAUD_RATE (115_200)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_last    (req_last),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .grant       (grant),
      .active      (active),
      .timeout_err (timeout_err),
      .state_dbg   (state_dbg),
      .ptr_dbg     (ptr_dbg)
   );

   // ---------------- clock / cycle count ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- requester sources ----------------
   // Entry {gap[7:0], last, data}: gap = cycles valid stays low after the previous byte's handshake.
   logic [16:0]  src_q[N][$];
   int           gap_left[N];
   logic [N-1:0] hs_seen;
   logic         start_seen;

   initial begin
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      for (int i = 0; i < N; i++) gap_left[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (hs_seen[i] && src_q[i].size() > 0) begin
               void'(src_q[i].pop_front());
               if (src_q[i].size() > 0) gap_left[i] = int'(src_q[i][0][16:9]);
            end
            if (gap_left[i] > 0) begin
               req_valid[i] = 1'b0;
               gap_left[i]--;
            end else if (src_q[i].size() > 0) begin
               req_valid[i]       = 1'b1;
               req_data[i*8 +: 8] = src_q[i][0][7:0];
               req_last[i]        = src_q[i][0][8];
            end else begin
               req_valid[i] = 1'b0;
               req_last[i]  = 1'b0;
            end
         end
      end
   end

   // ---------------- TX core model ----------------
   int busy_left = 0;
   bit stuck = 1'b0;
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            busy_left = 0;
         end else if (start_seen && !stuck) begin
            busy_left = BUSY_CYC;
         end else if (busy_left > 0) begin
            busy_left--;
         end
         tx_busy = (busy_left > 0);
      end
   end

   // ---------------- reference model ----------------
   logic [8:0]   m_bytes[N][$];
   int           model_ptr = 0;
   logic [W-1:0] exp_q[$];

   task automatic add_byte(input int r, input logic [7:0] d, input bit last, input int gap);
      src_q[r].push_back({8'(gap), last, d});
      m_bytes[r].push_back({last, d});
   endtask

   task automatic add_rand_packet(input int r, input int len);
      for (int b = 0; b < len; b++)
         add_byte(r, 8'($urandom_range(0, 255)), (b == len - 1), (b == 0) ? 0 : $urandom_range(0, 200));
   endtask

   // Whole-packet round robin: pick the first requester with a pending packet
   // starting at the pointer, emit its packet, then move the pointer past it.
   task automatic commit();
      int         j;
      bit         pending;
      logic [8:0] b;
      logic [3:0] gm;
      forever begin
         pending = 1'b0;
         for (int i = 0; i < N; i++) if (m_bytes[i].size() > 0) pending = 1'b1;
         if (!pending) break;
         j = model_ptr;
         for (int k = 0; k < N; k++) begin
            j = (model_ptr + k) % N;
            if (m_bytes[j].size() > 0) break;
         end
         gm = 4'(1 << j);
         do begin
            b = m_bytes[j].pop_front();
            exp_q.push_back({gm, b[7:0]});
         end while (!b[8] && m_bytes[j].size() > 0);
         model_ptr = (j + 1) % N;
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   int   to_cnt = 0;
   int   to_cyc = 0;
   int   start_cyc = 0;
   int   hs_cyc = -100;
   int   rdy_cnt[N];
   bit   prev_start = 1'b0;

   initial begin
      logic [W-1:0] exp;
      hs_seen    = '0;
      start_seen = 1'b0;
      for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hs_seen    = '0;
            start_seen = 1'b0;
            prev_start = 1'b0;
            continue;
         end
         start_seen = tx_start;
         hs_seen    = req_valid & req_ready;
         for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
         if (req_ready != '0) begin
            check("ready_granted_only", 32'(req_ready & ~grant), 0);
            check("ready_follows_valid", 32'(req_ready & ~req_valid), 0);
         end
         if (timeout_err) begin
            to_cnt++;
            to_cyc = cyc;
         end
         if (tx_start) begin
            check("start_one_cycle", 32'(prev_start), 0);
            check("start_after_handshake", 32'(cyc - hs_cyc), 1);
            start_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_start: actual %0h/%0h required none", grant, tx_data);
            end else begin
               exp = exp_q.pop_front();
               check("tx_grant_data", 32'({grant, tx_data}), 32'(exp));
            end
         end
         if (|hs_seen) hs_cyc = cyc;
         prev_start = tx_start;
      end
   end

   // ---------------- test helpers ----------------
   function automatic bit src_empty();
      bit e;
      e = 1'b1;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) e = 1'b0;
      return e;
   endfunction

   task automatic wait_quiet(input string name, input int limit);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(state_dbg == IDLE && !tx_busy && exp_q.size() == 0 && src_empty()) && n < limit);
      check(name, 32'(n < limit), 1);
   endtask

   task automatic clear_rdy();
      for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_state", 32'(state_dbg), 32'(IDLE));
      check("rst_grant", 32'(grant), 0);
      check("rst_active", 32'(active), 0);
      check("rst_tx_start", 32'(tx_start), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_timeout", 32'(timeout_err), 0);
      check("rst_ptr", 32'(ptr_dbg), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Single byte from requester 0
      clear_rdy();
      add_byte(0, 8'h41, 1'b1, 0);
      commit();
      wait_quiet("single_done", 2000);
      check("single_ready0_cycles", 32'(rdy_cnt[0]), 1);
      check("single_ptr", 32'(ptr_dbg), 32'(model_ptr));

      // Requester 3 alone wraps the pointer back to 0
      add_byte(3, 8'h30, 1'b1, 0);
      commit();
      wait_quiet("wrap_done", 2000);
      check("wrap_ptr", 32'(ptr_dbg), 32'(model_ptr));

      // Packet lock: requester 0 three bytes while requester 2 waits
      add_byte(0, 8'h10, 1'b0, 0);
      add_byte(0, 8'h11, 1'b0, 0);
      add_byte(0, 8'h12, 1'b1, 0);
      add_byte(2, 8'h20, 1'b1, 0);
      commit();
      wait_quiet("lock_done", 4000);
      check("lock_ptr", 32'(ptr_dbg), 32'(model_ptr));

      add_byte(3, 8'h31, 1'b1, 0);
      commit();
      wait_quiet("wrap2_done", 2000);

      // Rotation: every requester offers two single-byte packets
      for (int rep = 0; rep < 2; rep++)
         for (int i = 0; i < N; i++) add_byte(i, 8'(8'h50 + rep * 4 + i), 1'b1, 0);
      commit();
      wait_quiet("rotation_done", 8000);
      check("rotation_ptr", 32'(ptr_dbg), 32'(model_ptr));

      // Stuck core: busy never rises
      stuck = 1'b1;
      add_byte(0, 8'h66, 1'b1, 0);
      commit();
      n = 0;
      while (to_cnt == 0 && n < 600) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("stuck_timeout_seen", 32'(to_cnt), 1);
      check("stuck_timeout_delay", 32'(to_cyc - start_cyc), 121);
      check("stuck_state_idle", 32'(state_dbg), 32'(IDLE));
      check("stuck_grant_clear", 32'(grant), 0);
      check("stuck_ptr", 32'(ptr_dbg), 32'(model_ptr));
      stuck = 1'b0;
      wait_quiet("stuck_quiet", 500);

      // Mid-packet stall short enough to survive (about 50 cycles in FETCH)
      add_byte(1, 8'hA0, 1'b0, 0);
      add_byte(1, 8'hA1, 1'b0, 152);
      add_byte(1, 8'hA2, 1'b1, 0);
      commit();
      wait_quiet("stall50_done", 4000);
      check("stall50_no_timeout", 32'(to_cnt), 1);
      check("stall50_ptr", 32'(ptr_dbg), 32'(model_ptr));

      // Mid-packet stall of about 130 cycles in FETCH aborts; remainder is re-granted later
      add_byte(1, 8'hB0, 1'b0, 0);
      add_byte(1, 8'hB1, 1'b1, 232);
      commit();
      wait_quiet("stall130_done", 4000);
      check("stall130_timeout", 32'(to_cnt), 2);
      check("stall130_ptr", 32'(ptr_dbg), 32'(model_ptr));

      // Randomized packets with mid-packet gaps below the abort threshold
      for (int round = 0; round < 2; round++) begin
         for (int p = 0; p < 6; p++) add_rand_packet($urandom_range(0, N - 1), $urandom_range(1, 4));
         commit();
         wait_quiet("random_done", 30000);
         check("random_no_timeout", 32'(to_cnt), 2);
         check("random_ptr", 32'(ptr_dbg), 32'(model_ptr));
      end

      // Asynchronous reset while waiting for the core to finish
      add_byte(2, 8'h77, 1'b1, 0);
      commit();
      n = 0;
      while (state_dbg != WAIT_DONE && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("reach_wait_done", 32'(state_dbg), 32'(WAIT_DONE));
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_state", 32'(state_dbg), 32'(IDLE));
      check("arst_grant", 32'(grant), 0);
      check("arst_active", 32'(active), 0);
      check("arst_tx_start", 32'(tx_start), 0);
      check("arst_tx_data", 32'(tx_data), 0);
      check("arst_ready", 32'(req_ready), 0);
      check("arst_ptr", 32'(ptr_dbg), 0);
      model_ptr = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      add_byte(3, 8'h33, 1'b1, 0);
      add_byte(1, 8'h31, 1'b1, 0);
      commit();
      wait_quiet("post_reset_done", 4000);
      check("post_reset_ptr", 32'(ptr_dbg), 32'(model_ptr));

      check("exp_q_drained", 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global bound on run time
   initial begin
      #600_000;
      n_err++;
      $display("FAIL watchdog: actual still running required finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmitter core between N_REQ byte-stream requesters. Each requester offers packets as a valid/ready byte stream with a LAST marker. The arbiter locks the channel to one requester for a whole packet and sequences each byte into the TX core through a start pulse and the core's busy flag. It sits between the application sources (button/switch logic, status reporters) and the UART TX core, and flags a stuck TX core with a timeout.

Parameters:
N_REQ, 4, number of requesters (2..8)
CLK_FREQ, 100_000_000, clock frequency in Hz
BAUD_RATE, 115_200, UART bit rate
TIMEOUT_CYC, 12*CLK_FREQ/BAUD_RATE, max cycles allowed in any wait state before abort (localparam-derivable, overridable)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
REQ_VALID  in  N_REQ  per-requester byte valid
REQ_LAST  in  N_REQ  per-requester last-byte-of-packet flag, qualified by REQ_VALID
REQ_DATA  in  8*N_REQ  per-requester byte; requester i on bits [8i+7:8i]
REQ_READY  out  N_REQ  byte accepted when REQ_VALID[i] & REQ_READY[i]
TX_START  out  1  one-cycle start pulse to UART TX core
TX_DATA  out  8  byte to UART TX core, stable from START until return to FETCH/IDLE
TX_BUSY  in  1  UART TX core busy flag
GRANT  out  N_REQ  one-hot owner of channel, 0 in IDLE
ACTIVE  out  1  high whenever state != IDLE
TIMEOUT_ERR  out  1  one-cycle pulse on abort

Behaviour:
- Reset (RST=0, async): state IDLE, all outputs 0, rr pointer 0, timeout counter 0, last flag 0.
- State machine: IDLE, FETCH, START, WAIT_BUSY, WAIT_DONE.
- IDLE: if any REQ_VALID, pick the first set bit searching from the pointer upward with wrap. Register GRANT to that one-hot value and go to FETCH. Otherwise stay in IDLE.
- FETCH: REQ_READY[g] = REQ_VALID[g], combinational, granted index only; all other READY bits stay 0.
  - On handshake: TX_DATA <= REQ_DATA[g], last_r <= REQ_LAST[g], go to START.
  - No valid: stay in FETCH (mid-packet stall) and count.
- START: TX_START=1 for exactly one cycle, then WAIT_BUSY.
- WAIT_BUSY: TX_BUSY=1 goes to WAIT_DONE.
- WAIT_DONE: TX_BUSY=0 goes to FETCH if last_r=0. If last_r=1, go to IDLE, clear GRANT, and set pointer to (g+1) mod N_REQ.
- Byte latency: handshake at cycle t, TX_START at t+1, earliest next READY at busy-fall+1.
- Timeout: counter clears on every state entry and increments each cycle in FETCH (only when last_r=0 mid-packet), WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT_CYC: TIMEOUT_ERR pulses 1 cycle, state goes to IDLE, GRANT clears, pointer advances past g.
  - The first FETCH of a packet also times out if the grantee drops VALID.
- Pointer changes only on packet completion or abort. A single requester streaming back-to-back packets is re-granted only if no other requester is valid.
- Non-granted REQ_VALID changes are ignored until IDLE.
- The grantee may drop VALID between bytes; LAST on a non-handshake cycle is ignored.
- TX_BUSY already high on START exit is legal and moves to WAIT_DONE next cycle.
- Reset mid-operation: everything returns to reset values immediately, and TX_START deasserts asynchronously. Recovery of the byte in flight is the TX core's responsibility.
- N_REQ=1 degenerates to a pass-through sequencer with pointer fixed at 0.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE, FETCH, START, WAIT_BUSY, WAIT_DONE)
  - BYTE_W=8
  - function clog2 for pointer/counter widths
- One sub-module, rr_arbiter: combinational first-set search from pointer with wrap. Inputs req[N_REQ] and ptr; outputs one-hot grant and any flag.

Test Plan:
Bench setup: CLK_FREQ=1_152_000, BAUD_RATE=115_200 (10 clk/bit, TIMEOUT_CYC=120), TX core model with busy for 100 cycles.
- Single byte: REQ0 sends 0x41 with LAST -> GRANT=0001, READY0 one cycle, TX_START one cycle later with TX_DATA=0x41, back to IDLE after busy falls, pointer=1.
- Packet lock: REQ0 sends 3 bytes 0x10,0x11,0x12 while REQ2 is valid -> TX_DATA order 0x10,0x11,0x12 with GRANT fixed at 0001, then GRANT=0100.
- Rotation fairness: all four requesters continuously send 1-byte packets -> grant order 0,1,2,3,0 and no READY on non-granted bits.
- Stuck core: TX_BUSY held 0 after TX_START -> TIMEOUT_ERR pulse exactly 120 cycles after WAIT_BUSY entry, state IDLE, pointer advanced.
- Mid-packet stall: REQ1 drops VALID for 50 cycles between bytes -> stays in FETCH with no TX_START and no error; a 130-cycle gap produces an abort.
- Async reset asserted during WAIT_DONE -> all outputs 0 within the same cycle; after release a new REQ3 byte is granted starting from pointer 0.
